// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared pipeline encodings (hazard FSM states, aluOp codes).
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } hz_state_e;

  localparam int           ALU_OP_W = 4;
  localparam logic [3:0]   ALU_NOP  = 4'd0;
  localparam logic [3:0]   ALU_MUL  = 4'd10;
  localparam logic [3:0]   ALU_DIV  = 4'd11;
  localparam logic [4:0]   REG_ZERO = 5'd0;

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// ============================================================================
// md_timer : loadable down-counter with zero flag; saturates at zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module md_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : load-use bubble and MUL/DIV stall sequencer for the
// 5-stage pipeline. MUL/DIV sequencing enabled by PIPE_HAZARD_MULDIV_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_rsRead,
  input  logic [4:0] id_rsAddr,
  input  logic       id_rtRead,
  input  logic [4:0] id_rtAddr,
  input  logic       id_isMulDiv,
  input  logic       ex_memRead,
  input  logic [4:0] ex_regWriteAddr,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_bubble,
  output logic       ex_hold,
  output logic       md_busy,
  output logic       md_done
);

  // Outputs stay quiet for the whole first cycle after reset release.
  logic live_q;
  logic live;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) live_q <= 1'b0;
    else       live_q <= 1'b1;
  end

  assign live = rstn & live_q;

  logic load_use;

  always_comb begin
    load_use = ex_memRead && (ex_regWriteAddr != REG_ZERO) &&
               ((id_rsRead && (id_rsAddr == ex_regWriteAddr)) ||
                (id_rtRead && (id_rtAddr == ex_regWriteAddr)));
  end

`ifdef PIPE_HAZARD_MULDIV_EN

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

  hz_state_e        state_q, state_d;
  logic             md_load, md_dec, md_zero;
  logic [CNT_W-1:0] md_cnt;

  md_timer #(.CNT_W(CNT_W)) u_md_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (md_load),
    .load_val (MD_LOAD),
    .dec      (md_dec),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Busy lasts MD_LOAD cycles: leave once the count is about to reach zero.
  always_comb begin
    state_d      = ST_IDLE;
    md_load      = 1'b0;
    md_dec       = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (live) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_isMulDiv) begin
            md_load = 1'b1;
            state_d = (MD_LOAD == '0) ? ST_MD_DONE : ST_MD_BUSY;
          end
        end
        ST_MD_BUSY: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          ex_hold     = 1'b1;
          md_busy     = 1'b1;
          md_dec      = 1'b1;
          state_d     = (md_zero || (md_cnt == CNT_W'(1))) ? ST_MD_DONE : ST_MD_BUSY;
        end
        ST_MD_DONE: begin
          md_done = 1'b1;
          if (id_isMulDiv) begin
            md_load = 1'b1;
            state_d = (MD_LOAD == '0) ? ST_MD_DONE : ST_MD_BUSY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`else

  logic [31:0] unused_cfg;
  assign unused_cfg = MD_CYCLES + CNT_W + {31'd0, id_isMulDiv};

  always_comb begin
    pc_stall     = live & load_use;
    if_id_stall  = live & load_use;
    id_ex_bubble = live & load_use;
    ex_hold      = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_rsRead, id_rtRead, id_isMulDiv, ex_memRead;
  logic [4:0] id_rsAddr, id_rtAddr, ex_regWriteAddr;
  logic       pc_stall, if_id_stall, id_ex_bubble, ex_hold, md_busy, md_done;

  int total = 0;
  int bad   = 0;

  // {pc_stall, if_id_stall, id_ex_bubble, ex_hold, md_busy, md_done}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_LU    = 6'b111000;
  localparam logic [5:0] O_BUSY  = 6'b110110;
  localparam logic [5:0] O_DONE  = 6'b000001;

  pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .id_rsRead       (id_rsRead),
    .id_rsAddr       (id_rsAddr),
    .id_rtRead       (id_rtRead),
    .id_rtAddr       (id_rtAddr),
    .id_isMulDiv     (id_isMulDiv),
    .ex_memRead      (ex_memRead),
    .ex_regWriteAddr (ex_regWriteAddr),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_bubble    (id_ex_bubble),
    .ex_hold         (ex_hold),
    .md_busy         (md_busy),
    .md_done         (md_done)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rsr, input logic [4:0] rsa, input logic rtr,
                       input logic [4:0] rta, input logic md, input logic mr,
                       input logic [4:0] wa);
    id_rsRead = rsr; id_rsAddr = rsa; id_rtRead = rtr; id_rtAddr = rta;
    id_isMulDiv = md; ex_memRead = mr; ex_regWriteAddr = wa;
  endtask

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_stall, if_id_stall, id_ex_bubble, ex_hold, md_busy, md_done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: check mid-cycle, then advance to the next posedge+1.
  task automatic cyc(input string tag, input logic [5:0] exp);
    #3;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
    @(posedge clk);
    #1;
    cyc("reset_hold_lu", O_IDLE);
    rstn = 1'b1;
    cyc("first_after_release", O_IDLE);
    cyc("lu_rs", O_LU);

    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0);
    cyc("lu_r0", O_IDLE);
    drive(1'b0, 5'd0, 1'b1, 5'd13, 1'b0, 1'b1, 5'd13);
    cyc("lu_rt", O_LU);
    drive(1'b0, 5'd13, 1'b0, 5'd13, 1'b0, 1'b1, 5'd13);
    cyc("no_read", O_IDLE);
    drive(1'b1, 5'd13, 1'b1, 5'd13, 1'b0, 1'b0, 5'd13);
    cyc("no_load", O_IDLE);
    drive(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13);
    cyc("addr_diff", O_IDLE);

`ifdef PIPE_HAZARD_MULDIV_EN
    // single op: issue, 2 busy, done, idle
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    cyc("md_issue", O_IDLE);
    drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
    cyc("md_busy1_lu_ignored", O_BUSY);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("md_busy2", O_BUSY);
    cyc("md_done", O_DONE);
    cyc("md_idle", O_IDLE);

    // back-to-back
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    cyc("b2b_issue", O_IDLE);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("b2b_busy1", O_BUSY);
    cyc("b2b_busy2", O_BUSY);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    cyc("b2b_done1", O_DONE);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("b2b_busy3", O_BUSY);
    cyc("b2b_busy4", O_BUSY);
    cyc("b2b_done2", O_DONE);
    cyc("b2b_idle", O_IDLE);

    // load-use wins over MUL/DIV
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9);
    cyc("lu_md_bubble", O_LU);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9);
    cyc("lu_md_issue", O_IDLE);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("lu_md_busy1", O_BUSY);
    cyc("lu_md_busy2", O_BUSY);
    cyc("lu_md_done", O_DONE);

    // async reset in the middle of MD_BUSY
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    cyc("rst_md_issue", O_IDLE);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("rst_md_busy1", O_BUSY);
    rstn = 1'b0;
    #1;
    check("rst_mid_busy", O_IDLE);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
    cyc("rst_md_first", O_IDLE);
    cyc("rst_md_idle_lu", O_LU);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("rst_md_quiet", O_IDLE);
`else
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    cyc("nomd_1", O_IDLE);
    cyc("nomd_2", O_IDLE);
    cyc("nomd_3", O_IDLE);
    cyc("nomd_4", O_IDLE);
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9);
    cyc("nomd_lu", O_LU);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("nomd_quiet", O_IDLE);
    rstn = 1'b0;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
    #1;
    check("nomd_rst_gate", O_IDLE);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc("nomd_first", O_IDLE);
    cyc("nomd_lu2", O_LU);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
